mem_acc_cont_ldst_port: RTL and testbench

Memory-access-controller port that terminates the SIMD core's LD/ST interface and drives one single-ported SRAM bank. It arbitrates bank ownership against the DMA engine with a request/grant/release handshake. It serialises LD/ST writes and reads onto the SRAM, tracks in-flight reads, and buffers read returns in a credit-checked queue so that `ldst__memc__read_pause` never loses data.

---
 rtl/mem_acc_cont_ldst_port.sv | 163 ++++++++++++++++
 tb/tb_mem_acc_cont_ldst_port.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_acc_cont_ldst_port.sv
// LD/ST port onto one SRAM bank: DMA ownership handshake, write-priority access,
// in-flight read tracking and a credit-checked return queue (optional MEM_ACC_CONT_LDST_RDQ_BYPASS_EN).
`ifndef MEM_ACC_CONT_MEMORY_ADDRESS_RANGE
`define MEM_ACC_CONT_MEMORY_ADDRESS_RANGE 15:0
`endif
`ifndef MEM_ACC_CONT_MEMORY_DATA_RANGE
`define MEM_ACC_CONT_MEMORY_DATA_RANGE 31:0
`endif

module mem_acc_cont_ldst_port #(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned RDQ_DEPTH    = 4
) (
  input  logic                                      clk,
  input  logic                                      reset_poweron,
  input  logic                                      ldst__memc__request,
  output logic                                      memc__ldst__granted,
  input  logic                                      ldst__memc__released,
  input  logic                                      dma__memc__busy,
  input  logic                                      ldst__memc__write_valid,
  input  logic [`MEM_ACC_CONT_MEMORY_ADDRESS_RANGE] ldst__memc__write_address,
  input  logic [`MEM_ACC_CONT_MEMORY_DATA_RANGE]    ldst__memc__write_data,
  output logic                                      memc__ldst__write_ready,
  input  logic                                      ldst__memc__read_valid,
  input  logic [`MEM_ACC_CONT_MEMORY_ADDRESS_RANGE] ldst__memc__read_address,
  output logic                                      memc__ldst__read_ready,
  output logic [`MEM_ACC_CONT_MEMORY_DATA_RANGE]    memc__ldst__read_data,
  output logic                                      memc__ldst__read_data_valid,
  input  logic                                      ldst__memc__read_pause,
  output logic                                      memc__sram__enable,
  output logic                                      memc__sram__write,
  output logic [`MEM_ACC_CONT_MEMORY_ADDRESS_RANGE] memc__sram__address,
  output logic [`MEM_ACC_CONT_MEMORY_DATA_RANGE]    memc__sram__write_data,
  input  logic [`MEM_ACC_CONT_MEMORY_DATA_RANGE]    sram__memc__read_data
);

  localparam int unsigned PTR_W = $clog2(RDQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANTED, S_DRAIN} state_e;
  typedef logic [`MEM_ACC_CONT_MEMORY_DATA_RANGE] data_t;

  state_e             state_q, state_d;
  logic               granted_q, granted_d;
  logic [READ_LATENCY-1:0] rd_sr_q, rd_sr_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic [CNT_W-1:0]   occ_q, occ_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  data_t              rdq_q [RDQ_DEPTH];
  data_t              rdq_d [RDQ_DEPTH];

  logic               wr_accept, rd_accept, rd_return;
  logic               q_empty, credit_ok, bypass, push, pop;
  logic [CNT_W:0]     credit_used;

  // Every accepted read reserves a queue slot until it is popped, so a push can never overrun.
  assign credit_used = {1'b0, inflight_q} + {1'b0, occ_q};
  assign credit_ok   = credit_used < (CNT_W+1)'(RDQ_DEPTH);

  assign memc__ldst__granted     = granted_q;
  assign memc__ldst__write_ready = granted_q;
  assign memc__ldst__read_ready  = granted_q & ~ldst__memc__write_valid & credit_ok;

  assign wr_accept = granted_q & ldst__memc__write_valid;
  assign rd_accept = memc__ldst__read_ready & ldst__memc__read_valid;
  assign rd_return = rd_sr_q[READ_LATENCY-1];
  assign q_empty   = (occ_q == '0);

`ifdef MEM_ACC_CONT_LDST_RDQ_BYPASS_EN
  assign bypass = rd_return & q_empty & ~ldst__memc__read_pause;
`else
  assign bypass = 1'b0;
`endif

  assign push = rd_return & ~bypass;
  assign pop  = ~q_empty & ~ldst__memc__read_pause;

  always_comb begin
    memc__sram__enable     = 1'b0;
    memc__sram__write      = 1'b0;
    memc__sram__address    = '0;
    memc__sram__write_data = '0;
    if (wr_accept) begin
      memc__sram__enable     = 1'b1;
      memc__sram__write      = 1'b1;
      memc__sram__address    = ldst__memc__write_address;
      memc__sram__write_data = ldst__memc__write_data;
    end else if (rd_accept) begin
      memc__sram__enable  = 1'b1;
      memc__sram__address = ldst__memc__read_address;
    end
  end

  always_comb begin
    memc__ldst__read_data_valid = ~q_empty | bypass;
    memc__ldst__read_data       = '0;
    if (!q_empty) begin
      memc__ldst__read_data = rdq_q[head_q];
    end else if (bypass) begin
      memc__ldst__read_data = sram__memc__read_data;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (ldst__memc__request && !dma__memc__busy) state_d = S_GRANTED;
      S_GRANTED: if (ldst__memc__released) state_d = S_DRAIN;
      S_DRAIN:   if (inflight_q == '0 && q_empty) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    granted_d = (state_d == S_GRANTED);

    rd_sr_d[0] = rd_accept;
    for (int unsigned i = 1; i < READ_LATENCY; i++) begin
      rd_sr_d[i] = rd_sr_q[i-1];
    end

    inflight_d = inflight_q;
    case ({rd_accept, rd_return})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase

    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase

    head_d = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d = push ? tail_q + PTR_W'(1) : tail_q;

    rdq_d = rdq_q;
    if (push) rdq_d[tail_q] = sram__memc__read_data;
  end

  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      state_q    <= S_IDLE;
      granted_q  <= 1'b0;
      rd_sr_q    <= '0;
      inflight_q <= '0;
      occ_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      for (int unsigned i = 0; i < RDQ_DEPTH; i++) rdq_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      granted_q  <= granted_d;
      rd_sr_q    <= rd_sr_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      rdq_q      <= rdq_d;
    end
  end

endmodule

// File: tb/tb_mem_acc_cont_ldst_port.sv
// Directed bench for mem_acc_cont_ldst_port (READ_LATENCY=2, RDQ_DEPTH=4) with a small SRAM model.
`ifndef MEM_ACC_CONT_MEMORY_ADDRESS_RANGE
`define MEM_ACC_CONT_MEMORY_ADDRESS_RANGE 15:0
`endif
`ifndef MEM_ACC_CONT_MEMORY_DATA_RANGE
`define MEM_ACC_CONT_MEMORY_DATA_RANGE 31:0
`endif

module tb_mem_acc_cont_ldst_port;
  typedef logic [`MEM_ACC_CONT_MEMORY_ADDRESS_RANGE] addr_t;
  typedef logic [`MEM_ACC_CONT_MEMORY_DATA_RANGE]    data_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b1;
  logic  request, granted, released, busy;
  logic  wv, wready, rv, rready, rdv, pause;
  addr_t waddr, raddr, sram_addr;
  data_t wdata, rdata, sram_wdata, sram_rdata;
  logic  sram_en, sram_we;

  int tests = 0;
  int failed = 0;

  data_t    sram_mem [256];
  bit [255:0] sram_wr;
  data_t    pipe0, pipe1;

  always #5 clk = ~clk;

  mem_acc_cont_ldst_port #(.READ_LATENCY(2), .RDQ_DEPTH(4)) dut (
    .clk                         (clk),
    .reset_poweron               (rst_n),
    .ldst__memc__request         (request),
    .memc__ldst__granted         (granted),
    .ldst__memc__released        (released),
    .dma__memc__busy             (busy),
    .ldst__memc__write_valid     (wv),
    .ldst__memc__write_address   (waddr),
    .ldst__memc__write_data      (wdata),
    .memc__ldst__write_ready     (wready),
    .ldst__memc__read_valid      (rv),
    .ldst__memc__read_address    (raddr),
    .memc__ldst__read_ready      (rready),
    .memc__ldst__read_data       (rdata),
    .memc__ldst__read_data_valid (rdv),
    .ldst__memc__read_pause      (pause),
    .memc__sram__enable          (sram_en),
    .memc__sram__write           (sram_we),
    .memc__sram__address         (sram_addr),
    .memc__sram__write_data      (sram_wdata),
    .sram__memc__read_data       (sram_rdata)
  );

  function automatic data_t exp_word(input addr_t a);
    return data_t'(32'h5000_0000) + data_t'(a);
  endfunction

  // Two-stage read pipe: data for an enable in cycle t is on sram_rdata in cycle t+2.
  always @(posedge clk) begin
    if (sram_en && sram_we) begin
      sram_mem[sram_addr[7:0]] <= sram_wdata;
      sram_wr[sram_addr[7:0]]  <= 1'b1;
    end
    pipe0 <= (sram_en && !sram_we) ?
             (sram_wr[sram_addr[7:0]] ? sram_mem[sram_addr[7:0]] : exp_word(sram_addr)) : '0;
    pipe1 <= pipe0;
  end
  assign sram_rdata = pipe1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    tests++; if (granted !== 1'b0) begin failed++; $error("FAIL %s_granted: observed=0x%0h", tag, granted); end
    tests++; if (wready !== 1'b0) begin failed++; $error("FAIL %s_write_ready: observed=0x%0h", tag, wready); end
    tests++; if (rready !== 1'b0) begin failed++; $error("FAIL %s_read_ready: observed=0x%0h", tag, rready); end
    tests++; if (rdv !== 1'b0) begin failed++; $error("FAIL %s_rdv: observed=0x%0h", tag, rdv); end
    tests++; if (rdata !== data_t'(0)) begin failed++; $error("FAIL %s_read_data: observed=0x%0h", tag, rdata); end
    tests++; if (sram_en !== 1'b0) begin failed++; $error("FAIL %s_sram_en: observed=0x%0h", tag, sram_en); end
    tests++; if (sram_we !== 1'b0) begin failed++; $error("FAIL %s_sram_we: observed=0x%0h", tag, sram_we); end
    tests++; if (sram_addr !== addr_t'(0)) begin failed++; $error("FAIL %s_sram_addr: observed=0x%0h", tag, sram_addr); end
    tests++; if (sram_wdata !== data_t'(0)) begin failed++; $error("FAIL %s_sram_wdata: observed=0x%0h", tag, sram_wdata); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int issued, recv, cyc;
    request = 0; released = 0; busy = 0; wv = 0; waddr = '0; wdata = '0;
    rv = 0; raddr = '0; pause = 0;

    #1 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    tick; tick;
    rst_n = 1'b1;
    tick;

    busy = 1; request = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      tests++; if (granted !== 1'b0) begin failed++; $error("FAIL busy_no_grant: observed=0x%0h expected=0x0", granted); end
      tick;
    end
    busy = 0;
    #1;
    tests++; if (granted !== 1'b0) begin failed++; $error("FAIL grant_before_edge: observed=0x%0h expected=0x0", granted); end
    tick;
    #1;
    tests++; if (granted !== 1'b1) begin failed++; $error("FAIL grant_plus1: observed=0x%0h expected=0x1", granted); end
    request = 0;

    tick;
    wv = 1; waddr = 16'h0010; wdata = data_t'(32'h0000_A5A5);
    rv = 1; raddr = 16'h0010;
    #1;
    tests++; if (wready !== 1'b1) begin failed++; $error("FAIL wr_ready: observed=0x%0h expected=0x1", wready); end
    tests++; if (sram_en !== 1'b1) begin failed++; $error("FAIL wr_sram_en: observed=0x%0h expected=0x1", sram_en); end
    tests++; if (sram_we !== 1'b1) begin failed++; $error("FAIL wr_sram_we: observed=0x%0h expected=0x1", sram_we); end
    tests++; if (sram_addr !== addr_t'(16'h0010)) begin failed++; $error("FAIL wr_sram_addr: observed=0x%0h expected=0x10", sram_addr); end
    tests++; if (sram_wdata !== data_t'(32'h0000_A5A5)) begin failed++; $error("FAIL wr_sram_wdata: observed=0x%0h expected=0xa5a5", sram_wdata); end
    tests++; if (rready !== 1'b0) begin failed++; $error("FAIL collide_read_ready: observed=0x%0h expected=0x0", rready); end
    tick;
    wv = 0; waddr = '0; wdata = '0;
    #1;
    tests++; if (rready !== 1'b1) begin failed++; $error("FAIL rd_ready: observed=0x%0h expected=0x1", rready); end
    tests++; if (sram_en !== 1'b1) begin failed++; $error("FAIL rd_sram_en: observed=0x%0h expected=0x1", sram_en); end
    tests++; if (sram_we !== 1'b0) begin failed++; $error("FAIL rd_sram_we: observed=0x%0h expected=0x0", sram_we); end
    tests++; if (sram_addr !== addr_t'(16'h0010)) begin failed++; $error("FAIL rd_sram_addr: observed=0x%0h expected=0x10", sram_addr); end
    tick;
    rv = 0;
    #1;
    tests++; if (sram_en !== 1'b0) begin failed++; $error("FAIL idle_sram_en: observed=0x%0h expected=0x0", sram_en); end
    tests++; if (sram_addr !== addr_t'(0)) begin failed++; $error("FAIL idle_sram_addr: observed=0x%0h expected=0x0", sram_addr); end
    tests++; if (rdv !== 1'b0) begin failed++; $error("FAIL rd_t1_rdv: observed=0x%0h expected=0x0", rdv); end
    tick;
    #1;
`ifdef MEM_ACC_CONT_LDST_RDQ_BYPASS_EN
    tests++; if (rdv !== 1'b1) begin failed++; $error("FAIL rd_t2_rdv: observed=0x%0h expected=0x1", rdv); end
    tests++; if (rdata !== data_t'(32'h0000_A5A5)) begin failed++; $error("FAIL rd_t2_data: observed=0x%0h expected=0xa5a5", rdata); end
`else
    tests++; if (rdv !== 1'b0) begin failed++; $error("FAIL rd_t2_rdv: observed=0x%0h expected=0x0", rdv); end
`endif
    tick;
    #1;
`ifdef MEM_ACC_CONT_LDST_RDQ_BYPASS_EN
    tests++; if (rdv !== 1'b0) begin failed++; $error("FAIL rd_t3_rdv: observed=0x%0h expected=0x0", rdv); end
`else
    tests++; if (rdv !== 1'b1) begin failed++; $error("FAIL rd_t3_rdv: observed=0x%0h expected=0x1", rdv); end
    tests++; if (rdata !== data_t'(32'h0000_A5A5)) begin failed++; $error("FAIL rd_t3_data: observed=0x%0h expected=0xa5a5", rdata); end
`endif
    tick;
    #1;
    tests++; if (rdv !== 1'b0) begin failed++; $error("FAIL rd_t4_rdv: observed=0x%0h expected=0x0", rdv); end

    pause = 1;
    tick;
    for (int k = 0; k < 4; k++) begin
      rv = 1; raddr = addr_t'(32'h20 + k);
      #1;
      tests++; if (rready !== 1'b1) begin failed++; $error("FAIL rdq_credit_open: observed=0x%0h expected=0x1", rready); end
      tick;
    end
    raddr = addr_t'(32'h24);
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++; if (rready !== 1'b0) begin failed++; $error("FAIL rdq_credit_closed: observed=0x%0h expected=0x0", rready); end
      tick;
    end
    #1;
    tests++; if (rdv !== 1'b1) begin failed++; $error("FAIL pause_hold_rdv: observed=0x%0h expected=0x1", rdv); end
    tests++; if (rdata !== exp_word(addr_t'(32'h20))) begin failed++; $error("FAIL pause_hold_data: observed=0x%0h expected=0x%0h", rdata, exp_word(addr_t'(32'h20))); end

    pause = 0; issued = 4; recv = 0; cyc = 0;
    while (recv < 8 && cyc < 80) begin
      rv = (issued < 8);
      raddr = addr_t'(32'h20 + issued);
      #1;
      if (rdv) begin
        tests++; if (rdata !== exp_word(addr_t'(32'h20 + recv))) begin failed++; $error("FAIL rdq_order: observed=0x%0h expected=0x%0h", rdata, exp_word(addr_t'(32'h20 + recv))); end
        recv++;
      end
      if (rv && rready) issued++;
      tick;
      cyc++;
    end
    rv = 0;
    tests++; if (recv != 8) begin failed++; $error("FAIL rdq_all_words: observed=%0d expected=8", recv); end

    tick; tick;
    pause = 1;
    for (int k = 0; k < 3; k++) begin
      rv = 1; raddr = addr_t'(32'h30 + k);
      #1;
      tests++; if (rready !== 1'b1) begin failed++; $error("FAIL drain_rd_accept: observed=0x%0h expected=0x1", rready); end
      tick;
    end
    rv = 0; released = 1; pause = 0; request = 1;
    recv = 0; cyc = 0;
    #1;
    if (rdv) begin
      tests++; if (rdata !== exp_word(addr_t'(32'h30 + recv))) begin failed++; $error("FAIL drain_order: observed=0x%0h expected=0x%0h", rdata, exp_word(addr_t'(32'h30 + recv))); end
      recv++;
    end
    tick;
    released = 0;
    #1;
    tests++; if (granted !== 1'b0) begin failed++; $error("FAIL drain_granted_low: observed=0x%0h expected=0x0", granted); end
    while (granted !== 1'b1 && cyc < 40) begin
      if (rdv) begin
        tests++; if (rdata !== exp_word(addr_t'(32'h30 + recv))) begin failed++; $error("FAIL drain_order: observed=0x%0h expected=0x%0h", rdata, exp_word(addr_t'(32'h30 + recv))); end
        recv++;
      end
      tick;
      #1;
      cyc++;
    end
    tests++; if (granted !== 1'b1) begin failed++; $error("FAIL drain_regrant: observed=0x%0h expected=0x1", granted); end
    tests++; if (recv != 3) begin failed++; $error("FAIL drain_words_before_grant: observed=%0d expected=3", recv); end
    request = 0;

    tick;
    rv = 1; raddr = addr_t'(32'h40);
    #1;
    tests++; if (rready !== 1'b1) begin failed++; $error("FAIL rst_rd0_accept: observed=0x%0h expected=0x1", rready); end
    tick;
    raddr = addr_t'(32'h41);
    #1;
    tests++; if (rready !== 1'b1) begin failed++; $error("FAIL rst_rd1_accept: observed=0x%0h expected=0x1", rready); end
    tick;
    rv = 0;
    #1 rst_n = 1'b0;
    #1 chk_all_zero("reset_midflight");
    tick; tick;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      #1;
      tests++; if (rdv !== 1'b0) begin failed++; $error("FAIL no_return_after_reset: observed=0x%0h expected=0x0", rdv); end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
